// File: rtl/prog_loader.sv
// Program loader: collects opcode/immediate nibble pairs over a ready/valid link,
// writes them to program memory, then hands the memory port to the CPU in RUN.
module prog_loader #(
   parameter int MAX_MEM = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_req,
   input  logic       run_req,
   input  logic [3:0] nib_in,
   input  logic       nib_valid,
   output logic       nib_ready,
   input  logic [3:0] cpu_pc,
   output logic       mem_write,
   output logic [3:0] mem_address,
   output logic [3:0] mem_opcode,
   output logic [3:0] mem_immediate,
   output logic       cpu_run,
   output logic       loading,
   output logic       load_done,
   output logic [7:0] checksum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_OP,
      S_LOAD_IMM,
      S_WRITE,
      S_RUN
   } state_t;

   localparam logic [3:0] LAST_PTR = 4'(MAX_MEM - 1);

   state_t     state_q, state_d;
   logic [3:0] wr_ptr_q;
   logic [3:0] op_q;
   logic [3:0] imm_q;
   logic [7:0] checksum_q;
   logic       load_done_q;
   logic       xfer;
   logic       last_word;
   logic       start_load;

   // nib_ready is a pure state decode, so xfer never feeds back into it.
   assign xfer      = nib_valid & nib_ready;
   assign last_word = (wr_ptr_q == LAST_PTR);

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (load_req)     state_d = S_LOAD_OP;
            else if (run_req) state_d = S_RUN;
         end
         S_LOAD_OP:  if (xfer) state_d = S_LOAD_IMM;
         S_LOAD_IMM: if (xfer) state_d = S_WRITE;
         S_WRITE:    state_d = last_word ? S_IDLE : S_LOAD_OP;
         S_RUN:      if (load_req) state_d = S_LOAD_OP;
         default:    state_d = S_IDLE;
      endcase
   end

   assign start_load = ((state_q == S_IDLE) || (state_q == S_RUN)) && (state_d == S_LOAD_OP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= 4'h0;
         op_q        <= 4'h0;
         imm_q       <= 4'h0;
         checksum_q  <= 8'h00;
         load_done_q <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         if (start_load) begin
            wr_ptr_q   <= 4'h0;
            checksum_q <= 8'h00;
         end
         if (state_q == S_LOAD_OP && xfer)  op_q  <= nib_in;
         if (state_q == S_LOAD_IMM && xfer) imm_q <= nib_in;
         if (state_q == S_WRITE) begin
            checksum_q <= checksum_q ^ {imm_q, op_q};
            // The pointer parks on the last address until the next load clears it.
            if (last_word) load_done_q <= 1'b1;
            else           wr_ptr_q    <= wr_ptr_q + 4'h1;
         end
      end
   end

   assign nib_ready     = (state_q == S_LOAD_OP) || (state_q == S_LOAD_IMM);
   assign loading       = nib_ready || (state_q == S_WRITE);
   assign mem_write     = (state_q == S_WRITE);
   assign cpu_run       = (state_q == S_RUN);
   assign load_done     = load_done_q;
   assign checksum      = checksum_q;
   assign mem_opcode    = op_q;
   assign mem_immediate = imm_q;

   always_comb begin
      mem_address = 4'h0;
      if (loading)      mem_address = wr_ptr_q;
      else if (cpu_run) mem_address = cpu_pc;
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver queues expected memory writes and
// load checksums, and a negedge monitor pops and compares them as the DUT presents them.
module tb_prog_loader;

   localparam int MAX = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_req = 1'b0;
   logic       run_req = 1'b0;
   logic [3:0] nib_in = 4'h0;
   logic       nib_valid = 1'b0;
   logic       nib_ready;
   logic [3:0] cpu_pc = 4'h0;
   logic       mem_write;
   logic [3:0] mem_address;
   logic [3:0] mem_opcode;
   logic [3:0] mem_immediate;
   logic       cpu_run;
   logic       loading;
   logic       load_done;
   logic [7:0] checksum;

   prog_loader #(.MAX_MEM(MAX)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_req     (load_req),
      .run_req      (run_req),
      .nib_in       (nib_in),
      .nib_valid    (nib_valid),
      .nib_ready    (nib_ready),
      .cpu_pc       (cpu_pc),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_opcode   (mem_opcode),
      .mem_immediate(mem_immediate),
      .cpu_run      (cpu_run),
      .loading      (loading),
      .load_done    (load_done),
      .checksum     (checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] addr;
      logic [3:0] op;
      logic [3:0] imm;
   } wr_t;

   wr_t        wq[$];
   logic [7:0] csq[$];
   int         compared = 0;
   int         mismatched = 0;
   int         phase = 0;
   bit         noise = 0;
   logic [3:0] ops[MAX];
   logic [3:0] imms[MAX];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe and load_done pulse is matched against the queues.
   logic prev_write = 1'b0;
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_write) begin
            check("write_one_cycle", {31'd0, prev_write}, 32'd0);
            check("ready_low_in_write", {31'd0, nib_ready}, 32'd0);
            check("loading_in_write", {31'd0, loading}, 32'd1);
            if (wq.size() == 0) begin
               check("unexpected_write", {20'd0, mem_address, mem_opcode, mem_immediate}, 32'hFFFF_FFFF);
            end else begin
               wr_t e;
               e = wq.pop_front();
               check("write_word", {20'd0, mem_address, mem_opcode, mem_immediate},
                     {20'd0, e.addr, e.op, e.imm});
            end
         end
         if (load_done) begin
            check("done_one_cycle", {31'd0, prev_done}, 32'd0);
            if (csq.size() == 0) begin
               check("unexpected_done", {24'd0, checksum}, 32'hFFFF_FFFF);
            end else begin
               logic [7:0] c;
               c = csq.pop_front();
               check("checksum", {24'd0, checksum}, {24'd0, c});
            end
         end
      end
      prev_write = mem_write;
      prev_done  = load_done;
   end

   task automatic check_reset_outputs(input string name);
      check(name, {8'd0, mem_write, nib_ready, cpu_run, loading, load_done, 3'd0,
                   mem_address, mem_opcode, mem_immediate, checksum}, 32'd0);
   endtask

   task automatic start_load(input bit with_run);
      load_req = 1'b1;
      run_req  = with_run;
      @(posedge clk); #1;
      load_req = 1'b0;
      run_req  = 1'b0;
      check("enter_loading", {31'd0, loading}, 32'd1);
      check("cpu_run_off_on_load", {31'd0, cpu_run}, 32'd0);
      check("ptr_cleared", {28'd0, mem_address}, 32'd0);
      check("checksum_cleared", {24'd0, checksum}, 32'd0);
   endtask

   // Present one nibble until it is accepted; returns at posedge+1 after the transfer edge.
   task automatic send_nib(input logic [3:0] n, input bit throttle);
      bit done = 0;
      int budget = 0;
      while (!done && budget < 40) begin
         nib_valid = throttle ? (phase % 3 == 0) : 1'b1;
         phase++;
         nib_in = nib_valid ? n : 4'($urandom);
         if (noise) begin
            load_req = 1'($urandom);
            run_req  = 1'($urandom);
         end
         @(negedge clk);
         done = nib_valid && nib_ready;
         @(posedge clk); #1;
         budget++;
      end
      check("nib_accepted", {31'd0, done}, 32'd1);
      nib_valid = 1'b0;
      load_req  = 1'b0;
      run_req   = 1'b0;
   endtask

   task automatic wait_load_done();
      bit seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = load_done;
      end
      check("load_done_seen", {31'd0, seen}, 32'd1);
      check("idle_after_load", {27'd0, loading, mem_address}, 32'd0);
      @(negedge clk);
      check("done_cleared", {31'd0, load_done}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_load(input bit throttle, input bit with_run);
      logic [7:0] cs = 8'h00;
      for (int k = 0; k < MAX; k++) cs ^= {imms[k], ops[k]};
      csq.push_back(cs);
      start_load(with_run);
      noise = with_run;
      for (int k = 0; k < MAX; k++) begin
         wq.push_back('{addr: 4'(k), op: ops[k], imm: imms[k]});
         send_nib(ops[k], throttle);
         send_nib(imms[k], throttle);
      end
      noise = 0;
      wait_load_done();
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < MAX; i++) begin
         ops[i]  = 4'(i);
         imms[i] = ~4'(i);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check_reset_outputs("reset_outputs");
      #19 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_no_run", {30'd0, cpu_run, loading}, 32'd0);

      // Full-speed load with the reference pattern.
      fill_pattern();
      do_load(1'b0, 1'b0);

      // Random data; load and run requested together, requests toggled while loading.
      for (int i = 0; i < MAX; i++) begin
         ops[i]  = 4'($urandom);
         imms[i] = 4'($urandom);
      end
      do_load(1'b0, 1'b1);

      // Run and fetch: address follows cpu_pc, no writes.
      run_req = 1'b1;
      @(posedge clk); #1;
      run_req = 1'b0;
      for (int pc = 0; pc < MAX; pc++) begin
         cpu_pc = 4'(pc);
         #1;
         check("fetch_addr", {28'd0, mem_address}, pc);
         check("fetch_run", {30'd0, cpu_run, mem_write}, 32'd2);
         @(posedge clk); #1;
      end

      // Reload from RUN at pc 5, throttled handshake with the reference pattern.
      cpu_pc = 4'd5;
      fill_pattern();
      do_load(1'b1, 1'b0);

      // Reset in LOAD_IMM of word 3: words 0..2 written, partial word dropped.
      start_load(1'b0);
      for (int k = 0; k < 3; k++) begin
         wq.push_back('{addr: 4'(k), op: ops[k], imm: imms[k]});
         send_nib(ops[k], 1'b0);
         send_nib(imms[k], 1'b0);
      end
      send_nib(ops[3], 1'b0);
      check("at_word3", {27'd0, nib_ready, mem_address}, 32'h13);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midload_reset_outputs");
      @(negedge clk);
      check_reset_outputs("midload_reset_hold");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_reset", {30'd0, cpu_run, loading}, 32'd0);

      check("write_queue_empty", wq.size(), 32'd0);
      check("checksum_queue_empty", csq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_MEM, default 8, meaning number of program words loaded per load sequence (1..16).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load_req  input  1  level; request to enter program-load mode.
REQ-005 SHALL have port run_req  input  1  level; request to start CPU execution.
REQ-006 SHALL have port nib_in  input  4  serial nibble data: opcode first, then immediate.
REQ-007 SHALL have port nib_valid  input  1  nib_in holds a valid nibble.
REQ-008 SHALL have port nib_ready  output  1  loader accepts a nibble this cycle.
REQ-009 SHALL have port cpu_pc  input  4  CPU program counter (fetch address).
REQ-010 SHALL have port mem_write  output  1  program-memory write strobe.
REQ-011 SHALL have port mem_address  output  4  program-memory address.
REQ-012 SHALL have port mem_opcode  output  4  opcode nibble to memory.
REQ-013 SHALL have port mem_immediate  output  4  immediate nibble to memory.
REQ-014 SHALL have port cpu_run  output  1  CPU clock-enable; high only in RUN.
REQ-015 SHALL have port loading  output  1  high in LOAD_OP, LOAD_IMM or WRITE.
REQ-016 SHALL have port load_done  output  1  single-cycle pulse when the last word is written.
REQ-017 SHALL have port checksum  output  8  XOR of all {immediate,opcode} words written in the current/last load.

Function
REQ-018 SHALL implement states IDLE, LOAD_OP, LOAD_IMM, WRITE, RUN in one registered state register.
REQ-019 SHALL, in IDLE: load_req -> LOAD_OP; else run_req -> RUN; load_req has priority when both high.
REQ-020 SHALL, on entry to LOAD_OP from IDLE or RUN, clear wr_ptr to 0 and checksum to 8'h00 in the same edge.
REQ-021 SHALL drive nib_ready=1 in LOAD_OP and LOAD_IMM only; 0 in all other states.
REQ-022 SHALL transfer a nibble only on a cycle with nib_valid & nib_ready; nib_valid without nib_ready is ignored and not buffered.
REQ-023 SHALL, on transfer in LOAD_OP, register nib_in into the opcode holding register and go to LOAD_IMM.
REQ-024 SHALL, on transfer in LOAD_IMM, register nib_in into the immediate holding register and go to WRITE.
REQ-025 SHALL remain in LOAD_OP/LOAD_IMM indefinitely while no transfer occurs (no timeout).
REQ-026 SHALL assert mem_write=1 for exactly the one cycle spent in WRITE, with mem_address=wr_ptr and mem_opcode/mem_immediate equal to the holding registers.
REQ-027 SHALL, on leaving WRITE, XOR {immediate,opcode} into checksum.
REQ-028 SHALL, leaving WRITE with wr_ptr<MAX_MEM-1, increment wr_ptr and go to LOAD_OP.
REQ-029 SHALL, leaving WRITE with wr_ptr==MAX_MEM-1, go to IDLE, pulse load_done for one cycle and leave wr_ptr unchanged (no wrap to 0 until next load).
REQ-030 SHALL drive mem_address=wr_ptr in LOAD_OP/LOAD_IMM/WRITE, cpu_pc in RUN, 4'h0 in IDLE.
REQ-031 SHALL drive mem_write=0 in every state other than WRITE; CPU never has write access.
REQ-032 SHALL, in RUN, go to LOAD_OP on load_req (cpu_run drops the next cycle); run_req deassertion alone does not leave RUN.
REQ-033 SHALL ignore load_req and run_req while loading (no restart, no abort).
REQ-034 SHALL produce all outputs from registers or decode of the state register only; no combinational path from nib_valid to nib_ready.

Reset
REQ-035 SHALL, on rst_n low, immediately enter IDLE with wr_ptr=0, holding registers=0, checksum=8'h00.
REQ-036 SHALL, during reset, hold mem_write=0, nib_ready=0, cpu_run=0, loading=0, load_done=0, mem_address=4'h0, mem_opcode=4'h0, mem_immediate=4'h0.
REQ-037 SHALL, on reset asserted mid-load, discard the partial word with no write strobe; words already written remain in memory untouched by this block.

Verification
REQ-038 SHALL cover full load: load_req, 16 nibbles with nib_valid held high (op=i, imm=~i for i=0..7) -> 8 writes addr 0..7 each one cycle, load_done after addr 7, checksum=8'h00.
REQ-039 SHALL cover throttled handshake: nib_valid toggled 1-of-3 cycles -> no lost/duplicated nibbles, nib_ready=0 during WRITE, same memory contents as full-speed load.
REQ-040 SHALL cover run/fetch: after load, run_req -> cpu_run=1, mem_address follows cpu_pc 0..7, mem_write stays 0.
REQ-041 SHALL cover reload from RUN: load_req while cpu_pc=5 -> cpu_run=0 next cycle, wr_ptr restarts at 0, checksum cleared.
REQ-042 SHALL cover simultaneous load_req & run_req in IDLE -> LOAD_OP entered, cpu_run stays 0.
REQ-043 SHALL cover reset mid-load: rst_n low in LOAD_IMM at word 3 -> no mem_write, all outputs at reset values, state IDLE.
